ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Pipeline control carrier and hazard unit: the consumer of the 10-bit control word produced by the opcode decoder. Registers the word through ID/EX, EX/MEM and MEM/WB, presenting the EX, MEM and WB fields to their stages. Detects load-use and RAW hazards, generates stall, bubble and flush behaviour, and drives EX operand forwarding selects. Sits between the decode stage and the datapath stage registers of the 5-stage core.

## Interface
- REG_W, 3, register-index width (8 architectural registers, r0 hardwired zero)
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all stages to bubble
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  10  decoder word: [9:8] ALU src, [7:5] ALU op, [4] MemWrite/MemRead, [3] BNE, [2] jump, [1] MemToReg, [0] RegWrite
- id_rs, id_rt, id_rd  in  REG_W each  source/destination indices of the ID instruction
- id_rs_used, id_rt_used  in  1 each  instruction reads rs / rt
- mem_redirect  in  1  MEM stage resolved a taken BNE or jump this cycle
- ex_alu_src  out  2  ; ex_alu_op  out  3  ; ex_rs, ex_rt  out  REG_W
- mem_write  out  1  ; mem_bne  out  1  ; mem_jump  out  1
- wb_mem_to_reg  out  1  ; wb_reg_write  out  1  ; wb_rd  out  REG_W
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- stall  out  1  hold PC and IF/ID this cycle

## Operation
- Per stage: valid bit plus control fields; a bubble is valid=0 with all control bits 0. All ctrl outputs are gated by their stage valid, so bubbles drive 0.
- ID/EX captures {id_ctrl, id_rs, id_rt, id_rd} when id_valid && !stall && !mem_redirect; otherwise loads bubble.
- EX/MEM captures ID/EX each cycle unless mem_redirect, which loads bubble. MEM/WB always captures EX/MEM (the redirecting instruction itself completes).
- Writer test per stage: valid && RegWrite && rd != 0.
- Load-use: stall = 1 when EX stage is writer with MemToReg=1 and (id_rs_used && id_rs==ex_rd or id_rt_used && id_rt==ex_rd) and id_valid.
- Forwarding (per operand, EX stage rs/rt): EX/MEM writer with matching rd -> 01 (priority); else MEM/WB writer matching -> 10; else 00. Operand used flags carried with ID/EX; unused operand -> 00.
- Register file write in WB is visible to the same-cycle ID read; no WB-to-ID hazard.
- mem_redirect has priority over stall: stall output forced 0 while mem_redirect=1.

## Timing
- Reset: all stage valids 0; every output 0, including stall, fwd_a, fwd_b.
- Latency: ID word accepted at edge N appears on ex_* in cycle N+1, mem_* in N+2, wb_* in N+3.
- stall, fwd_a, fwd_b combinational from current stage registers and ID inputs; no extra cycle.
- Load-use costs exactly one bubble; next cycle EX holds bubble, the load is in MEM, forwarding 10 then serves the dependent instruction.
- Redirect: on the edge where mem_redirect=1, ID/EX and EX/MEM both become bubbles (2 squashed slots); IF/ID squashing is the fetch unit's job.
- Reset asserted mid-operation: all stages bubble on that edge regardless of stall/redirect.

## Configuration
- CTRL_FWD_EN defined: forwarding as above; stall only on load-use.
- Not defined: fwd_a/fwd_b tied 00; stall = 1 when id_valid and a used source matches rd of any writer in EX or EX/MEM stage (MemToReg irrelevant); MEM/WB needs no stall (write-through regfile).

## Test plan
- Reset held 2 cycles with id_valid=1, id_ctrl=10'h3FF -> all outputs 0 during and one cycle after release.
- ADD r1 (ctrl 10'h001, rd=1) then SUB reading rs=1 -> with CTRL_FWD_EN fwd_a=01 in SUB's EX cycle, stall never 1; without, stall=1 for 2 cycles.
- Load r2 (ctrl 10'h103, rd=2) followed by user rt=2 -> stall=1 one cycle, bubble in EX, then fwd_b=10.
- Writer with rd=0 followed by reader rs=0 -> fwd_a=00, stall=0.
- BNE in MEM with mem_redirect=1 while load-use condition present -> stall=0, next cycle ex_* and mem_* all 0, wb shows BNE fields (reg_write 0).
- Back-to-back writers rd=3 then reader rs=3 -> fwd_a=01 (EX/MEM wins over MEM/WB).

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline control carrier and hazard unit.
// Carries the decoder control word through ID/EX, EX/MEM and MEM/WB, detects
// RAW / load-use hazards, generates stall and bubbles, and drives EX operand
// forwarding selects.
// Build option: define CTRL_FWD_EN to enable EX operand forwarding (stall only
// on load-use). Without it, fwd_a/fwd_b are tied 00 and any RAW dependence on
// an instruction in EX or MEM stalls ID until the writer reaches WB.
module ctrl_pipe #(
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [9:0]       id_ctrl,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             mem_redirect,
  output logic [1:0]       ex_alu_src,
  output logic [2:0]       ex_alu_op,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             mem_write,
  output logic             mem_bne,
  output logic             mem_jump,
  output logic             wb_mem_to_reg,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall
);

  // ID/EX keeps the whole word; later stages keep only the fields still consumed.
  logic             ex_valid;
  logic [9:0]       ex_ctrl;
  logic [REG_W-1:0] ex_rs_q;
  logic [REG_W-1:0] ex_rt_q;
  logic [REG_W-1:0] ex_rd_q;

  logic             mem_valid;
  logic [4:0]       mem_ctrl;
  logic [REG_W-1:0] mem_rd_q;

  logic             wb_valid;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] wb_rd_q;

  logic id_accept;
  logic ex_writer;
  logic mem_writer;
  logic ex_rs_hit;
  logic ex_rt_hit;
  logic stall_raw;

  assign ex_writer  = ex_valid  && ex_ctrl[0]  && (ex_rd_q  != '0);
  assign mem_writer = mem_valid && mem_ctrl[0] && (mem_rd_q != '0);

  assign ex_rs_hit = id_rs_used && (id_rs == ex_rd_q);
  assign ex_rt_hit = id_rt_used && (id_rt == ex_rd_q);

  // A redirect squashes whatever ID holds, so it never needs to be held.
  assign stall     = id_valid && stall_raw && !mem_redirect;
  assign id_accept = id_valid && !stall && !mem_redirect;

  // ID/EX register: take the ID instruction or insert a bubble.
  always_ff @(posedge clk) begin
    if (reset || !id_accept) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs_q  <= '0;
      ex_rt_q  <= '0;
      ex_rd_q  <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= id_ctrl;
      ex_rs_q  <= id_rs;
      ex_rt_q  <= id_rt;
      ex_rd_q  <= id_rd;
    end
  end

  // EX/MEM register: advance ID/EX; a redirect kills the younger instruction.
  always_ff @(posedge clk) begin
    if (reset || mem_redirect) begin
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd_q  <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl[4:0];
      mem_rd_q  <= ex_rd_q;
    end
  end

  // MEM/WB register: always advances; the redirecting instruction completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_ctrl  <= '0;
      wb_rd_q  <= '0;
    end else begin
      wb_valid <= mem_valid;
      wb_ctrl  <= mem_ctrl[1:0];
      wb_rd_q  <= mem_rd_q;
    end
  end

`ifdef CTRL_FWD_EN
  logic ex_rs_used_q;
  logic ex_rt_used_q;
  logic wb_writer;

  assign wb_writer = wb_valid && wb_ctrl[0] && (wb_rd_q != '0);

  // Operand-used flags travel with the instruction so unused operands never forward.
  always_ff @(posedge clk) begin
    if (reset || !id_accept) begin
      ex_rs_used_q <= 1'b0;
      ex_rt_used_q <= 1'b0;
    end else begin
      ex_rs_used_q <= id_rs_used;
      ex_rt_used_q <= id_rt_used;
    end
  end

  // Forward selects: the younger result (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid && ex_rs_used_q) begin
      if (mem_writer && (mem_rd_q == ex_rs_q))     fwd_a = 2'b01;
      else if (wb_writer && (wb_rd_q == ex_rs_q))  fwd_a = 2'b10;
    end
    if (ex_valid && ex_rt_used_q) begin
      if (mem_writer && (mem_rd_q == ex_rt_q))     fwd_b = 2'b01;
      else if (wb_writer && (wb_rd_q == ex_rt_q))  fwd_b = 2'b10;
    end
  end

  // Only a load in EX cannot be forwarded in time.
  assign stall_raw = ex_writer && ex_ctrl[1] && (ex_rs_hit || ex_rt_hit);
`else
  logic mem_rs_hit;
  logic mem_rt_hit;

  assign mem_rs_hit = id_rs_used && (id_rs == mem_rd_q);
  assign mem_rt_hit = id_rt_used && (id_rt == mem_rd_q);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  // Hold ID until every pending writer has reached WB (write-through regfile).
  assign stall_raw = (ex_writer  && (ex_rs_hit  || ex_rt_hit)) ||
                     (mem_writer && (mem_rs_hit || mem_rt_hit));
`endif

  // Stage outputs, gated by stage valid so bubbles drive zero.
  always_comb begin
    ex_alu_src    = ex_valid  ? ex_ctrl[9:8] : 2'b00;
    ex_alu_op     = ex_valid  ? ex_ctrl[7:5] : 3'b000;
    ex_rs         = ex_valid  ? ex_rs_q      : '0;
    ex_rt         = ex_valid  ? ex_rt_q      : '0;
    mem_write     = mem_valid && mem_ctrl[4];
    mem_bne       = mem_valid && mem_ctrl[3];
    mem_jump      = mem_valid && mem_ctrl[2];
    wb_mem_to_reg = wb_valid  && wb_ctrl[1];
    wb_reg_write  = wb_valid  && wb_ctrl[0];
    wb_rd         = wb_valid  ? wb_rd_q      : '0;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe; expectations follow the CTRL_FWD_EN build option.
module tb_ctrl_pipe;

  localparam int REG_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [9:0]       id_ctrl;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_rs_used, id_rt_used;
  logic             mem_redirect;
  logic [1:0]       ex_alu_src;
  logic [2:0]       ex_alu_op;
  logic [REG_W-1:0] ex_rs, ex_rt;
  logic             mem_write, mem_bne, mem_jump;
  logic             wb_mem_to_reg, wb_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall;
  logic [23:0]      outs;

  int n_checks = 0;
  int n_fails  = 0;

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .mem_redirect(mem_redirect),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_write(mem_write), .mem_bne(mem_bne), .mem_jump(mem_jump),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
  );

  always #5 clk = ~clk;

  assign outs = {ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_write, mem_bne, mem_jump,
                 wb_mem_to_reg, wb_reg_write, wb_rd, fwd_a, fwd_b, stall};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd,
                       input logic ru, input logic tu);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_used = ru; id_rt_used = tu;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    // Reset held two cycles with a full-ones word presented
    reset = 1'b1; mem_redirect = 1'b0;
    drive(1'b1, 10'h3FF, 1, 2, 3, 1'b1, 1'b1);
    tick();
    check("reset_edge1_outs", outs, 0);
    tick();
    check("reset_edge2_outs", outs, 0);
    reset = 1'b0;
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("release_outs", outs, 0);
    tick();
    check("after_release_outs", outs, 0);

    // Latency and field placement: src=10 op=101 memwrite jump, rs5 rt6 rd7
    drive(1'b1, 10'h2B4, 5, 6, 7, 1'b1, 1'b1);
    check("lat_stall", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("lat_ex_alu_src", ex_alu_src, 2);
    check("lat_ex_alu_op", ex_alu_op, 5);
    check("lat_ex_rs", ex_rs, 5);
    check("lat_ex_rt", ex_rt, 6);
    check("lat_mem_write_n1", mem_write, 0);
    tick();
    check("lat_ex_bubble", ex_alu_op, 0);
    check("lat_mem_write", mem_write, 1);
    check("lat_mem_jump", mem_jump, 1);
    check("lat_mem_bne", mem_bne, 0);
    tick();
    check("lat_wb_rd", wb_rd, 7);
    check("lat_wb_reg_write", wb_reg_write, 0);
    check("lat_mem_write_n3", mem_write, 0);
    tick();
    check("lat_wb_rd_gone", wb_rd, 0);
    drain();

    // ADD r1 then SUB reading r1
    drive(1'b1, 10'h001, 2, 3, 1, 1'b1, 1'b1);
    check("add_stall", stall, 0);
    tick();
    drive(1'b1, 10'h021, 1, 4, 5, 1'b1, 1'b1);
`ifdef CTRL_FWD_EN
    check("sub_stall_fwd", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("sub_ex_op", ex_alu_op, 1);
    check("sub_fwd_a", fwd_a, 1);
    check("sub_fwd_b", fwd_b, 0);
    check("sub_stall_after", stall, 0);
`else
    check("sub_stall_c1", stall, 1);
    tick();
    check("sub_stall_c2", stall, 1);
    check("sub_ex_bubble", ex_alu_op, 0);
    tick();
    check("sub_stall_c3", stall, 0);
    check("add_wb_reg_write", wb_reg_write, 1);
    check("add_wb_rd", wb_rd, 1);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("sub_ex_op", ex_alu_op, 1);
    check("sub_ex_rs", ex_rs, 1);
    check("sub_fwd_a", fwd_a, 0);
`endif
    drain();

    // Load r2 then user of rt=2
    drive(1'b1, 10'h103, 3, 0, 2, 1'b1, 1'b0);
    check("ld_stall", stall, 0);
    tick();
    drive(1'b1, 10'h041, 4, 2, 6, 1'b1, 1'b1);
    check("ldu_stall_c1", stall, 1);
    tick();
    check("ldu_ex_op_bubble", ex_alu_op, 0);
    check("ldu_ex_src_bubble", ex_alu_src, 0);
`ifdef CTRL_FWD_EN
    check("ldu_stall_c2", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("ldu_ex_op", ex_alu_op, 2);
    check("ldu_fwd_b", fwd_b, 2);
    check("ldu_fwd_a", fwd_a, 0);
    check("ldu_wb_mem_to_reg", wb_mem_to_reg, 1);
`else
    check("ldu_stall_c2", stall, 1);
    tick();
    check("ldu_stall_c3", stall, 0);
    check("ldu_wb_mem_to_reg", wb_mem_to_reg, 1);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("ldu_ex_op", ex_alu_op, 2);
    check("ldu_fwd_b", fwd_b, 0);
`endif
    drain();

    // Writer to r0 then reader of r0
    drive(1'b1, 10'h001, 1, 1, 0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 10'h021, 0, 7, 4, 1'b1, 1'b1);
    check("r0_stall", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("r0_ex_op", ex_alu_op, 1);
    check("r0_fwd_a", fwd_a, 0);
    drain();

    // Redirect from BNE in MEM while a load-use pair sits in EX/ID
    drive(1'b1, 10'h008, 1, 2, 5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 10'h103, 3, 0, 2, 1'b1, 1'b0);
    check("rd_ld_stall", stall, 0);
    tick();
    mem_redirect = 1'b1;
    drive(1'b1, 10'h041, 4, 2, 6, 1'b1, 1'b1);
    check("rd_stall_forced0", stall, 0);
    check("rd_mem_bne", mem_bne, 1);
    tick();
    mem_redirect = 1'b0;
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("rd_ex_fields", {ex_alu_src, ex_alu_op, ex_rs, ex_rt}, 0);
    check("rd_mem_fields", {mem_write, mem_bne, mem_jump}, 0);
    check("rd_wb_rd", wb_rd, 5);
    check("rd_wb_reg_write", wb_reg_write, 0);
    tick();
    check("rd_load_squashed", wb_mem_to_reg, 0);
    check("rd_wb_rd_after", wb_rd, 0);
    drain();

    // Back-to-back writers of r3 then reader of r3
    drive(1'b1, 10'h001, 4, 5, 3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 10'h001, 4, 5, 3, 1'b0, 1'b0);
    check("b2b_w2_stall", stall, 0);
    tick();
    drive(1'b1, 10'h021, 3, 6, 7, 1'b1, 1'b1);
`ifdef CTRL_FWD_EN
    check("b2b_stall", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("b2b_fwd_a", fwd_a, 1);
    check("b2b_fwd_b", fwd_b, 0);
`else
    check("b2b_stall_c1", stall, 1);
    tick();
    check("b2b_stall_c2", stall, 1);
    tick();
    check("b2b_stall_c3", stall, 0);
    tick();
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    check("b2b_ex_rs", ex_rs, 3);
    check("b2b_fwd_a", fwd_a, 0);
`endif
    drain();

    // Unused rt never stalls, then reset mid-operation
    drive(1'b1, 10'h103, 3, 0, 2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 10'h001, 4, 2, 5, 1'b1, 1'b0);
    check("unused_rt_stall", stall, 0);
    tick();
    check("mid_ex_rs", ex_rs, 4);
    reset = 1'b1;
    drive(1'b1, 10'h3FF, 1, 2, 3, 1'b1, 1'b1);
    tick();
    check("mid_reset_outs", outs, 0);
    reset = 1'b0;
    drive(1'b0, 10'h000, 0, 0, 0, 1'b0, 1'b0);
    tick();
    check("post_reset_outs", outs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
